// File: rtl/instr_fetch.sv
// instr_fetch: issues PC reads to instruction memory and buffers in-order responses for decode.
module instr_fetch #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_i,
    input  logic            pc_valid_i,
    output logic            pc_ready_o,
    input  logic            flush_i,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_rsp_valid_i,
    input  logic [XLEN-1:0] imem_rsp_data_i,
    input  logic            imem_rsp_err_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    output logic            instr_fault_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

    logic [XLEN-1:0] pq_mem [DEPTH];
    logic [AW-1:0]   pq_wr, pq_rd;
    logic [CW-1:0]   pq_cnt;
    logic [XLEN-1:0] of_instr [DEPTH];
    logic [XLEN-1:0] of_pc [DEPTH];
    logic [DEPTH-1:0] of_fault;
    logic [AW-1:0]   of_wr, of_rd;
    logic [CW-1:0]   of_cnt, drop_cnt;
    logic [CW+1:0]   used;
    logic            credit, issue, rsp_drop, rsp_take, of_pop;

    // Every slot is claimed at issue, so a response always finds room in the out FIFO.
    assign used             = (CW+2)'(pq_cnt) + (CW+2)'(drop_cnt) + (CW+2)'(of_cnt);
    assign credit           = used < (CW+2)'(DEPTH);
    assign imem_req_valid_o = pc_valid_i & credit & ~flush_i;
    assign imem_req_addr_o  = pc_i;
    assign pc_ready_o       = imem_req_ready_i & credit & ~flush_i;
    assign issue            = imem_req_valid_o & imem_req_ready_i;
    assign rsp_drop         = imem_rsp_valid_i & (drop_cnt != '0);
    assign rsp_take         = imem_rsp_valid_i & (drop_cnt == '0) & (pq_cnt != '0);
    assign of_pop           = instr_valid_o & instr_ready_i;
    assign instr_valid_o    = of_cnt != '0;
    assign instr_o          = of_instr[of_rd];
    assign instr_pc_o       = of_pc[of_rd];
    assign instr_fault_o    = of_fault[of_rd];

    // Pending-queue pointers: push on issue, pop when a live response returns.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pq_wr  <= '0;
            pq_rd  <= '0;
            pq_cnt <= '0;
        end else if (flush_i) begin
            pq_wr  <= '0;
            pq_rd  <= '0;
            pq_cnt <= '0;
        end else begin
            if (issue) pq_wr <= pq_wr + 1'b1;
            if (rsp_take) pq_rd <= pq_rd + 1'b1;
            pq_cnt <= pq_cnt + CW'(issue) - CW'(rsp_take);
        end
    end

    // Pending-queue storage holds the PC of each live request.
    always_ff @(posedge clk) begin
        if (issue) pq_mem[pq_wr] <= pc_i;
    end

    // Requests orphaned by a flush are counted so their responses can be discarded.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) drop_cnt <= '0;
        else if (flush_i) drop_cnt <= drop_cnt + pq_cnt - CW'(imem_rsp_valid_i && (drop_cnt != '0 || pq_cnt != '0));
        else if (rsp_drop) drop_cnt <= drop_cnt - 1'b1;
    end

    // Out-FIFO pointers: push on a live response, pop on the decode handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            of_wr  <= '0;
            of_rd  <= '0;
            of_cnt <= '0;
        end else if (flush_i) begin
            of_wr  <= '0;
            of_rd  <= '0;
            of_cnt <= '0;
        end else begin
            if (rsp_take) of_wr <= of_wr + 1'b1;
            if (of_pop) of_rd <= of_rd + 1'b1;
            of_cnt <= of_cnt + CW'(rsp_take) - CW'(of_pop);
        end
    end

    // Out-FIFO storage; a faulted fetch is replaced by a NOP so decode stays harmless.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                of_instr[i] <= '0;
                of_pc[i]    <= '0;
            end
            of_fault <= '0;
        end else if (rsp_take && !flush_i) begin
            of_instr[of_wr] <= imem_rsp_err_i ? NOP : imem_rsp_data_i;
            of_pc[of_wr]    <= pq_mem[pq_rd];
            of_fault[of_wr] <= imem_rsp_err_i;
        end
    end

    // A response with nothing outstanding means the memory broke the ordering contract.
    rsp_has_owner: assert property (@(posedge clk) disable iff (!rst)
        imem_rsp_valid_i |-> (pq_cnt != '0 || drop_cnt != '0));
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: scoreboard bench for instr_fetch with an in-order variable-latency memory model.
module tb_instr_fetch;
    localparam int DEPTH = 2;
    localparam int XLEN  = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [XLEN-1:0] pc_i = '0;
    logic            pc_valid_i = 1'b0;
    logic            pc_ready_o;
    logic            flush_i = 1'b0;
    logic            imem_req_valid_o;
    logic            imem_req_ready_i = 1'b1;
    logic [XLEN-1:0] imem_req_addr_o;
    logic            imem_rsp_valid_i = 1'b0;
    logic [XLEN-1:0] imem_rsp_data_i = '0;
    logic            imem_rsp_err_i = 1'b0;
    logic            instr_valid_o;
    logic            instr_ready_i = 1'b1;
    logic [XLEN-1:0] instr_o;
    logic [XLEN-1:0] instr_pc_o;
    logic            instr_fault_o;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
        bit          err;
    } mreq_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        fault;
    } exp_t;

    mreq_t       mem_q[$];
    exp_t        exp_q[$];
    logic [31:0] src_q[$];
    int          cyc = 0;
    int          lat = 1;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] err_pc = '1;

    instr_fetch #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .pc_i(pc_i), .pc_valid_i(pc_valid_i), .pc_ready_o(pc_ready_o),
        .flush_i(flush_i), .imem_req_valid_o(imem_req_valid_o), .imem_req_ready_i(imem_req_ready_i),
        .imem_req_addr_o(imem_req_addr_o), .imem_rsp_valid_i(imem_rsp_valid_i),
        .imem_rsp_data_i(imem_rsp_data_i), .imem_rsp_err_i(imem_rsp_err_i),
        .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i), .instr_o(instr_o),
        .instr_pc_o(instr_pc_o), .instr_fault_o(instr_fault_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return 32'h0050_0093 + (a << 12);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        n_checks++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp_v, cyc);
        end
    endtask

    // One clock: drive PC, check outputs against the model, update memory and scoreboard.
    task automatic tick();
        mreq_t r;
        exp_t  e;
        bit    credit_m, fire;
        pc_valid_i = src_q.size() != 0;
        pc_i = pc_valid_i ? src_q[0] : '0;
        #1;
        credit_m = (mem_q.size() + exp_q.size()) < DEPTH;
        check("req_valid", imem_req_valid_o, pc_valid_i & credit_m & ~flush_i);
        check("pc_ready", pc_ready_o, imem_req_ready_i & credit_m & ~flush_i);
        check("instr_valid", instr_valid_o, exp_q.size() != 0);
        if (instr_valid_o && instr_ready_i && !flush_i) begin
            if (exp_q.size() == 0) check("spurious_instr", instr_valid_o, 0);
            else begin
                e = exp_q.pop_front();
                check("instr", instr_o, e.instr);
                check("instr_pc", instr_pc_o, e.pc);
                check("instr_fault", instr_fault_o, e.fault);
            end
        end
        fire = imem_req_valid_o && imem_req_ready_i;
        if (fire) check("req_addr", imem_req_addr_o, pc_i);
        if (flush_i) begin
            foreach (mem_q[i]) mem_q[i].stale = 1'b1;
            exp_q.delete();
        end
        if (imem_rsp_valid_i && mem_q.size() != 0) begin
            r = mem_q.pop_front();
            if (!r.stale) exp_q.push_back('{r.err ? 32'h0000_0013 : mem_data(r.addr), r.addr, r.err});
        end
        if (fire) begin
            mem_q.push_back('{pc_i, cyc + 1 + lat, 1'b0, pc_i == err_pc});
            void'(src_q.pop_front());
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        imem_rsp_valid_i = mem_q.size() != 0 && mem_q[0].due <= cyc + 1;
        imem_rsp_data_i = imem_rsp_valid_i ? mem_data(mem_q[0].addr) : '0;
        imem_rsp_err_i = imem_rsp_valid_i && mem_q[0].err;
    endtask

    task automatic drain(input int max);
        int n = 0;
        while ((src_q.size() + mem_q.size() + exp_q.size()) != 0 && n < max) begin
            tick();
            n++;
        end
        check("drain_timeout", src_q.size() + mem_q.size() + exp_q.size(), 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_valid", instr_valid_o, 0);
        check("rst_instr", instr_o, 0);
        check("rst_pc", instr_pc_o, 0);
        check("rst_fault", instr_fault_o, 0);
        check("rst_pc_ready", pc_ready_o, imem_req_ready_i);
        rst = 1'b1;
        // Memory not ready: PC stalls, then first fetch of pc 0.
        imem_req_ready_i = 1'b0;
        src_q = '{32'h0};
        repeat (2) tick();
        imem_req_ready_i = 1'b1;
        drain(20);
        // Streaming fetch.
        src_q = '{32'h0, 32'h4, 32'h8, 32'hC};
        drain(40);
        // Decode stalled until credit runs out, then released.
        instr_ready_i = 1'b0;
        src_q = '{32'h20, 32'h24, 32'h28};
        repeat (6) tick();
        check("s3_stalled", pc_ready_o, 0);
        instr_ready_i = 1'b1;
        drain(40);
        // Flush with two requests in flight.
        lat = 3;
        src_q = '{32'h100, 32'h104};
        for (int i = 0; i < 10 && mem_q.size() < 2; i++) tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("s4_drop_after_flush", dut.drop_cnt, 2);
        src_q = '{32'h200};
        drain(40);
        check("s4_drop_done", dut.drop_cnt, 0);
        // Flush coincident with a response and a buffered entry.
        lat = 2;
        instr_ready_i = 1'b0;
        src_q = '{32'h300, 32'h304};
        for (int i = 0; i < 10 && !(exp_q.size() == 1 && imem_rsp_valid_i); i++) tick();
        check("s5_buffered", instr_valid_o, 1);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("s5_empty", instr_valid_o, 0);
        check("s5_drop", dut.drop_cnt, 0);
        instr_ready_i = 1'b1;
        drain(20);
        // Bus error on pc 8.
        lat = 1;
        err_pc = 32'h8;
        src_q = '{32'h4, 32'h8, 32'hC};
        drain(40);
        err_pc = '1;
        // Reset mid-stream.
        lat = 3;
        instr_ready_i = 1'b0;
        src_q = '{32'h400, 32'h404, 32'h408};
        repeat (4) tick();
        check("s7_pre_valid", instr_valid_o, 1);
        #2 rst = 1'b0;
        #1;
        check("s7_rst_valid", instr_valid_o, 0);
        check("s7_rst_instr", instr_o, 0);
        check("s7_rst_pc", instr_pc_o, 0);
        check("s7_rst_fault", instr_fault_o, 0);
        mem_q.delete();
        exp_q.delete();
        src_q.delete();
        pc_valid_i = 1'b0;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_err_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        check("s7_pc_ready", pc_ready_o, imem_req_ready_i);
        lat = 1;
        instr_ready_i = 1'b1;
        src_q = '{32'h0};
        drain(20);
        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage sitting directly downstream of the program counter in the rv32i core.
- Accepts PCs over a valid/ready handshake, issues word reads to instruction memory, and matches in-order responses to their PCs.
- Buffers fetched words in a small FIFO and presents {instr, pc, fault} to decode over valid/ready.
- Supports a flush for branches and jumps; responses already in flight at flush time are discarded.

Parameters:
DEPTH, 2, total slots shared by in-flight requests and buffered instructions (power of 2, >=2)
XLEN, 32, address/data width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
pc_i  in  XLEN  fetch address from program counter
pc_valid_i  in  1  pc_i valid
pc_ready_o  out  1  pc_i accepted this cycle (stalls PC when low)
flush_i  in  1  redirect: discard all buffered/in-flight fetches
imem_req_valid_o  out  1  memory read request valid
imem_req_ready_i  in  1  memory accepts request
imem_req_addr_o  out  XLEN  request address
imem_rsp_valid_i  in  1  response valid (in order, always accepted)
imem_rsp_data_i  in  XLEN  instruction word
imem_rsp_err_i  in  1  bus error on this response
instr_valid_o  out  1  instruction available to decode
instr_ready_i  in  1  decode accepts
instr_o  out  XLEN  instruction word
instr_pc_o  out  XLEN  PC of instr_o
instr_fault_o  out  1  fetch fault for this entry

Behaviour:
- State:
  - pending queue: PCs of live in-flight requests, DEPTH entries.
  - out FIFO: {instr, pc, fault}, DEPTH entries.
  - drop_cnt: responses still to be discarded, width clog2(DEPTH)+1.
- Credit: credit = (pending_cnt + drop_cnt + out_cnt) < DEPTH.
  - Credit guarantees every response has an out FIFO slot, so no response backpressure exists.
- Request path is combinational:
  - imem_req_valid_o = pc_valid_i & credit & ~flush_i
  - imem_req_addr_o = pc_i
  - pc_ready_o = imem_req_ready_i & credit & ~flush_i
- Issue fires when imem_req_valid_o & imem_req_ready_i. On issue, pc_i is pushed into the pending queue.
- Memory contract: minimum response latency is 1 cycle; responses return in request order.
- Response handling (imem_rsp_valid_i):
  - If drop_cnt>0: drop_cnt decrements; data discarded; pending queue untouched.
  - Else: pop pending queue head; push {data, head pc, err} into out FIFO.
- Output: instr_* driven from the out FIFO head (registered). Response at edge N is visible on instr_valid_o after edge N, i.e. latency 1 cycle.
  - Pop on instr_valid_o & instr_ready_i.
  - Push and pop in the same cycle are allowed.
- Flush (flush_i=1, takes priority over everything that cycle):
  - out FIFO and pending queue are emptied.
  - drop_cnt <= drop_cnt + pending_cnt - (imem_rsp_valid_i ? 1 : 0). A response in the flush cycle counts as dropped.
  - No issue occurs; instr_valid_o is 0 from the next cycle.
  - Decode must ignore the instr_* handshake during the flush cycle; the pop is ignored.
- Error: imem_rsp_err_i sets instr_fault_o for that entry. instr_o = 32'h0000_0013 (NOP) when faulted. Fetch continues normally.
- Full: credit=0 → pc_ready_o=0; pc_i must be held by the upstream stage.
- Empty: instr_valid_o=0; instr_o/instr_pc_o are don't-care.
- Protocol violation: a response with pending_cnt=0 and drop_cnt=0 is ignored (assertion in sim).
- Pointer wrap: pointers are clog2(DEPTH) bits and wrap modulo DEPTH; counts are clog2(DEPTH)+1 bits.
- Reset (async assert, sync deassert externally):
  - all pointers, counts and drop_cnt = 0
  - instr_valid_o=0, instr_fault_o=0, instr_o=0, instr_pc_o=0
  - Reset mid-operation abandons in-flight requests; memory is reset by the same rst.

Test Plan:
1. Reset → instr_valid_o=0, pc_ready_o=imem_req_ready_i. Present pc_i=0 with a memory of fixed 1-cycle latency returning 0x00500093 → one cycle after the response, instr_valid_o=1, instr_o=0x00500093, instr_pc_o=0.
2. Streaming pc 0,4,8,12 with instr_ready_i=1, 1-cycle memory → four instructions out in order with matching PCs; sustained issue limited only by credit.
3. Hold instr_ready_i=0, DEPTH=2: after 2 issues, pc_ready_o=0 and stays 0. Release ready → one pop per cycle, pc_ready_o reasserts once credit is available.
4. Two requests in flight (pc 0x100, 0x104, latency 3), flush_i pulsed → both responses discarded, drop_cnt returns to 0. Next pc 0x200 → its instruction emerges with instr_pc_o=0x200.
5. Flush coincident with a response and a buffered entry → buffered entry lost, response dropped, drop_cnt = pending_cnt-1. No instr_valid_o next cycle.
6. Response with imem_rsp_err_i=1 for pc 0x8 → instr_fault_o=1, instr_o=0x00000013, instr_pc_o=0x8. Next fetch is normal with fault=0.
7. Assert rst mid-stream (entries buffered, requests in flight) → outputs clear immediately. After release, the first fetch behaves as in scenario 1.
